vpp_wave_gen: RTL and testbench
===============================

VPP_WAVE_GEN -- requirements
Module: vpp_wave_gen

Interface
REQ-001 SHALL have parameter DW, default 12: sample width.
REQ-002 SHALL have parameter WIN, default 2048: DC-mode period_start interval in samples.
REQ-003 SHALL have port clk, input, 1: single clock, all logic posedge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port en, input, 1: 1 = emit one sample per clk; 0 = pause.
REQ-006 SHALL have port mode, input, 2: 0 triangle, 1 square, 2 sawtooth, 3 DC.
REQ-007 SHALL have port cfg_max, input, DW: upper level.
REQ-008 SHALL have port cfg_min, input, DW: lower level.
REQ-009 SHALL have port step, input, DW: ramp increment per sample.
REQ-010 SHALL have port half_period, input, 11: square half-period minus 1, in samples.
REQ-011 SHALL have port data_out, output, DW: sample, registered.
REQ-012 SHALL have port data_valid, output, 1: data_out is a new sample this cycle.
REQ-013 SHALL have port period_start, output, 1: one-cycle pulse marking the first sample of a period.

Function
REQ-014 SHALL use states IDLE, RISE, FALL, HIGH, LOW, DCS; all transitions occur only on cycles with en=1.
REQ-015 SHALL snapshot mode, hi=max(cfg_max,cfg_min), lo=min(cfg_max,cfg_min), step, half_period into shadow registers on leaving IDLE and at every period boundary (cycle where period_start is driven to 1); config changes elsewhere SHALL NOT affect output.
REQ-016 SHALL treat shadow step of 0 as 1.
REQ-017 SHALL register data_valid = en with one-cycle latency; first sample appears the cycle after en first rises from IDLE.
REQ-018 SHALL, with en=0, hold data_out, state and counters, and drive data_valid=0 and period_start=0.
REQ-019 IDLE exit by mode: triangle/sawtooth -> RISE with data_out=lo; square -> HIGH with data_out=hi; DC -> DCS with data_out=hi; period_start=1 on that sample.
REQ-020 Triangle RISE: next = data_out+step computed in DW+1 bits; if >= hi then data_out=hi and go FALL, else data_out=next.
REQ-021 Triangle FALL: next = data_out-step in DW+1 signed bits; if <= lo then data_out=lo, go RISE, period_start=1, else data_out=next.
REQ-022 Sawtooth RISE: as REQ-020, but on reaching hi the following sample is lo with period_start=1 (state stays RISE).
REQ-023 Square: HIGH outputs hi for half_period+1 samples, LOW outputs lo for half_period+1 samples; period_start=1 on first HIGH sample.
REQ-024 DC: data_out=hi every sample; period_start=1 on first sample and every WIN samples thereafter.
REQ-025 hi==lo SHALL yield constant output in every mode, with period boundaries still generated (triangle: every 2 samples).
REQ-026 A mode change SHALL take effect at the next period boundary, entering the new mode's start state per REQ-019.
REQ-027 SHALL never emit a sample outside [lo,hi] of the current shadow config.

Reset
REQ-028 On rst=1 at a clk edge SHALL set state IDLE, data_out=0, data_valid=0, period_start=0, counters 0, shadow regs 0.
REQ-029 rst SHALL take priority over en; rst mid-period SHALL abandon the period, and the next sample after release with en=1 follows REQ-019.

Verification
REQ-030 Triangle, lo=100, hi=400, step=100, en=1 -> 100(ps),200,300,400,300,200,100(ps),200...
REQ-031 Triangle, lo=0, hi=4095, step=3000 -> 0,3000,4095,1095,0(ps); no wrap past bounds.
REQ-032 Square, cfg_max=10, cfg_min=3000 (swapped), half_period=1 -> 3000,3000,10,10,3000(ps) repeating.
REQ-033 Sawtooth lo=0, hi=5, step=0 -> 0,1,2,3,4,5,0(ps); cfg_max changed to 2 mid-ramp -> applied only from the 0 sample.
REQ-034 en dropped for 3 cycles mid-triangle -> data_valid=0, data_out held, sequence resumes at next value; DC mode WIN=2048 -> ps exactly every 2048 valid samples.
REQ-035 rst asserted mid-FALL -> next cycle data_out=0, data_valid=0; after release first sample = lo with period_start=1.

Source files
------------

// File: rtl/vpp_wave_gen_if.sv
// vpp_wave_gen bundle: enable, config and sample stream.
// master drives en/cfg and takes samples; slave is the generator.
interface vpp_wave_gen_if #(
  parameter int DW = 12
);
  logic          en;
  logic [1:0]    mode;
  logic [DW-1:0] cfg_max;
  logic [DW-1:0] cfg_min;
  logic [DW-1:0] step;
  logic [10:0]   half_period;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          period_start;

  modport master (
    output en, mode, cfg_max, cfg_min,
    output step, half_period,
    input  data_out, data_valid, period_start
  );

  modport slave (
    input  en, mode, cfg_max, cfg_min,
    input  step, half_period,
    output data_out, data_valid, period_start
  );
endinterface

// File: rtl/vpp_wave_gen.sv
// Triangle/square/sawtooth/DC sample generator, one sample per en cycle.
// Ports: clk, rst (sync, active-high), bus (slave: en, cfg in; samples out).
module vpp_wave_gen #(
  parameter int DW  = 12,
  parameter int WIN = 2048
) (
  input  logic           clk,
  input  logic           rst,
  vpp_wave_gen_if.slave  bus
);

  localparam int CW =
    ($clog2(WIN) > 11) ? $clog2(WIN) : 11;

  localparam logic [1:0] M_SQR = 2'd1;
  localparam logic [1:0] M_SAW = 2'd2;
  localparam logic [1:0] M_DC  = 2'd3;

  typedef enum logic [2:0] {
    IDLE, RISE, FALL, HIGH, LOW, DCS
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          ps_q, ps_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    mode_q, mode_d;
  logic [DW-1:0] hi_q, hi_d;
  logic [DW-1:0] lo_q, lo_d;
  logic [DW-1:0] step_q, step_d;
  logic [10:0]   hp_q, hp_d;

  logic [DW-1:0] live_hi, live_lo, step_eff;
  logic [DW:0]   sum;
  logic [DW+1:0] diff;
  logic          rise_top, fall_low;
  logic          restart;

  assign live_hi = (bus.cfg_max >= bus.cfg_min) ?
                   bus.cfg_max : bus.cfg_min;
  assign live_lo = (bus.cfg_max >= bus.cfg_min) ?
                   bus.cfg_min : bus.cfg_max;

  assign step_eff = (step_q == '0) ? DW'(1) : step_q;

  // Extra headroom bits so ramps clamp instead of wrapping.
  assign sum  = {1'b0, data_q} + {1'b0, step_eff};
  assign diff = {2'b0, data_q} - {2'b0, step_eff};

  assign rise_top = (sum >= {1'b0, hi_q});
  assign fall_low =
    ($signed(diff) <= $signed({2'b0, lo_q}));

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = bus.en;
    ps_d    = 1'b0;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    step_d  = step_q;
    hp_d    = hp_q;
    restart = 1'b0;

    if (bus.en) begin
      unique case (state_q)
        IDLE: restart = 1'b1;
        RISE: begin
          // Sawtooth sits at hi for one sample,
          // then wraps as a new period.
          if (mode_q == M_SAW && data_q >= hi_q)
            restart = 1'b1;
          else if (rise_top) begin
            data_d = hi_q;
            if (mode_q != M_SAW)
              state_d = FALL;
          end else
            data_d = sum[DW-1:0];
        end
        FALL: begin
          if (fall_low)
            restart = 1'b1;
          else
            data_d = diff[DW-1:0];
        end
        HIGH: begin
          if (cnt_q == CW'(hp_q)) begin
            state_d = LOW;
            data_d  = lo_q;
            cnt_d   = '0;
          end else
            cnt_d = cnt_q + CW'(1);
        end
        LOW: begin
          if (cnt_q == CW'(hp_q))
            restart = 1'b1;
          else
            cnt_d = cnt_q + CW'(1);
        end
        DCS: begin
          if (cnt_q == CW'(WIN - 1))
            restart = 1'b1;
          else
            cnt_d = cnt_q + CW'(1);
        end
        default: state_d = IDLE;
      endcase

      // Period boundary: take a fresh config
      // snapshot and emit the new mode's first sample.
      if (restart) begin
        ps_d   = 1'b1;
        cnt_d  = '0;
        mode_d = bus.mode;
        hi_d   = live_hi;
        lo_d   = live_lo;
        step_d = bus.step;
        hp_d   = bus.half_period;
        unique case (bus.mode)
          M_SQR: begin
            state_d = HIGH;
            data_d  = live_hi;
          end
          M_DC: begin
            state_d = DCS;
            data_d  = live_hi;
          end
          default: begin
            state_d = RISE;
            data_d  = live_lo;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      ps_q    <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      step_q  <= '0;
      hp_q    <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ps_q    <= ps_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      step_q  <= step_d;
      hp_q    <= hp_d;
    end
  end

  assign bus.data_out     = data_q;
  assign bus.data_valid   = valid_q;
  assign bus.period_start = ps_q;

endmodule

// File: tb/tb_vpp_wave_gen.sv
// Self-checking bench for vpp_wave_gen.
// Reference builds each period as a queue of samples.
module tb_vpp_wave_gen;

  localparam int DW  = 12;
  localparam int WIN = 2048;

  logic clk;
  logic rst;

  vpp_wave_gen_if #(.DW(DW)) bus ();

  vpp_wave_gen #(
    .DW (DW),
    .WIN(WIN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  int q[$];
  int m_data;
  int m_valid;
  int m_ps;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // One whole period of samples from a config snapshot.
  function automatic void build(int md, int a, int b,
                                int st, int hp);
    int hi, lo, s, v;
    hi = (a > b) ? a : b;
    lo = (a < b) ? a : b;
    s  = (st == 0) ? 1 : st;
    q.delete();
    case (md)
      0: begin
        q.push_back(lo);
        v = lo;
        do begin
          v = (v + s >= hi) ? hi : v + s;
          q.push_back(v);
        end while (v < hi);
        v = hi - s;
        while (v > lo) begin
          q.push_back(v);
          v = v - s;
        end
      end
      1: begin
        repeat (hp + 1) q.push_back(hi);
        repeat (hp + 1) q.push_back(lo);
      end
      2: begin
        q.push_back(lo);
        v = lo;
        while (v < hi) begin
          v = (v + s >= hi) ? hi : v + s;
          q.push_back(v);
        end
      end
      default: repeat (WIN) q.push_back(hi);
    endcase
  endfunction

  function automatic void model_step(bit e, bit r);
    if (r) begin
      q.delete();
      m_data  = 0;
      m_valid = 0;
      m_ps    = 0;
    end else if (e) begin
      m_ps = 0;
      if (q.size() == 0) begin
        build(int'(bus.mode), int'(bus.cfg_max),
              int'(bus.cfg_min), int'(bus.step),
              int'(bus.half_period));
        m_ps = 1;
      end
      m_data  = q.pop_front();
      m_valid = 1;
    end else begin
      m_valid = 0;
      m_ps    = 0;
    end
  endfunction

  task automatic cyc(input bit e, input bit r);
    bus.en = e;
    rst    = r;
    @(posedge clk);
    model_step(e, r);
    #1;
    check("data",  32'(bus.data_out),     32'(m_data));
    check("valid", 32'(bus.data_valid),   32'(m_valid));
    check("ps",    32'(bus.period_start), 32'(m_ps));
  endtask

  task automatic seq(input string tag,
                     input int ev[$], input int ep[$]);
    foreach (ev[i]) begin
      cyc(1'b1, 1'b0);
      check({tag, "_d"}, 32'(bus.data_out), 32'(ev[i]));
      check({tag, "_p"}, 32'(bus.period_start),
            32'(ep[i]));
    end
  endtask

  task automatic set_cfg(input int md, input int a,
                         input int b, input int st,
                         input int hp);
    bus.mode        = 2'(md);
    bus.cfg_max     = 12'(a);
    bus.cfg_min     = 12'(b);
    bus.step        = 12'(st);
    bus.half_period = 11'(hp);
  endtask

  task automatic rand_cfg();
    int base;
    if ($urandom_range(0, 1) == 0)
      set_cfg($urandom_range(0, 2),
              $urandom_range(0, 4095),
              $urandom_range(0, 4095),
              $urandom_range(0, 4095),
              $urandom_range(0, 7));
    else begin
      base = $urandom_range(0, 4000);
      set_cfg($urandom_range(0, 2),
              base + $urandom_range(0, 20), base,
              $urandom_range(0, 6),
              $urandom_range(0, 3));
    end
  endtask

  initial begin
    int ev[$];
    int ep[$];
    int dc_cnt;
    int dc_ps;
    bit e;
    bit r;
    n_chk  = 0;
    n_fail = 0;
    m_data = 0;
    m_valid = 0;
    m_ps = 0;
    rst = 1'b1;
    bus.en = 1'b0;
    set_cfg(0, 0, 0, 0, 0);

    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    check("rst_d", 32'(bus.data_out), 0);
    check("rst_v", 32'(bus.data_valid), 0);
    check("rst_p", 32'(bus.period_start), 0);
    cyc(1'b0, 1'b0);
    check("idle_v", 32'(bus.data_valid), 0);

    set_cfg(0, 400, 100, 100, 0);
    ev = '{100, 200, 300, 400, 300, 200, 100, 200};
    ep = '{1, 0, 0, 0, 0, 0, 1, 0};
    seq("tri", ev, ep);

    repeat (3) begin
      cyc(1'b0, 1'b0);
      check("hold_d", 32'(bus.data_out), 200);
      check("hold_v", 32'(bus.data_valid), 0);
      check("hold_p", 32'(bus.period_start), 0);
    end
    ev = '{300, 400, 300};
    ep = '{0, 0, 0};
    seq("resume", ev, ep);

    cyc(1'b1, 1'b1);
    check("rstf_d", 32'(bus.data_out), 0);
    check("rstf_v", 32'(bus.data_valid), 0);
    ev = '{100, 200};
    ep = '{1, 0};
    seq("rel", ev, ep);
    cyc(1'b0, 1'b1);

    set_cfg(0, 4095, 0, 3000, 0);
    ev = '{0, 3000, 4095, 1095, 0, 3000};
    ep = '{1, 0, 0, 0, 1, 0};
    seq("wide", ev, ep);
    cyc(1'b0, 1'b1);

    set_cfg(1, 10, 3000, 5, 1);
    ev = '{3000, 3000, 10, 10, 3000, 3000, 10};
    ep = '{1, 0, 0, 0, 1, 0, 0};
    seq("sqr", ev, ep);
    cyc(1'b0, 1'b1);

    set_cfg(2, 5, 0, 0, 0);
    ev = '{0, 1, 2};
    ep = '{1, 0, 0};
    seq("saw1", ev, ep);
    bus.cfg_max = 12'd2;
    ev = '{3, 4, 5, 0, 1, 2, 0};
    ep = '{0, 0, 0, 1, 0, 0, 1};
    seq("saw2", ev, ep);
    cyc(1'b0, 1'b1);

    set_cfg(0, 50, 50, 7, 0);
    ev = '{50, 50, 50};
    ep = '{1, 0, 1};
    seq("flat", ev, ep);
    set_cfg(1, 400, 100, 1, 0);
    ev = '{50, 400, 100, 400};
    ep = '{0, 1, 0, 1};
    seq("mchg", ev, ep);
    cyc(1'b0, 1'b1);

    set_cfg(3, 77, 900, 1, 0);
    dc_cnt = 0;
    dc_ps  = 0;
    for (int i = 0; i < 6000 && dc_ps < 3; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        bus.cfg_max = 12'($urandom_range(0, 4095));
        bus.cfg_min = 12'($urandom_range(0, 4095));
      end
      cyc($urandom_range(0, 9) != 0, 1'b0);
      if (bus.data_valid && bus.period_start) begin
        if (dc_ps > 0)
          check("dc_win", 32'(dc_cnt), WIN);
        dc_ps++;
        dc_cnt = 1;
      end else if (bus.data_valid)
        dc_cnt++;
    end
    check("dc_ps", 32'(dc_ps), 3);
    cyc(1'b0, 1'b1);

    for (int s = 0; s < 40; s++) begin
      rand_cfg();
      for (int c = 0; c < 250; c++) begin
        if ($urandom_range(0, 15) == 0)
          rand_cfg();
        e = ($urandom_range(0, 7) != 0);
        r = ($urandom_range(0, 199) == 0);
        cyc(e, r);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
